// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: control bit positions,
// default field widths and the occupancy state encoding.
package pipe_pkg;

    localparam int CTRL_WREG  = 0;
    localparam int CTRL_M2REG = 1;
    localparam int CTRL_WMEM  = 2;

    localparam int PIPE_CW = 3;
    localparam int PIPE_RW = 5;
    localparam int PIPE_DW = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    function automatic logic [1:0] state_occ(input state_e st);
        logic [1:0] n;
        case (st)
            ST_EMPTY: n = 2'd0;
            ST_ONE:   n = 2'd1;
            ST_TWO:   n = 2'd2;
            default:  n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and bubble masking of the control field.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int          CW   = PIPE_CW,
    parameter int          RW   = PIPE_RW,
    parameter int          DW   = PIPE_DW,
    parameter int unsigned SKID = 32'd1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_ctrl,
    input  logic [RW-1:0] in_rn,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_ctrl,
    output logic [RW-1:0] out_rn,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occ
);

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [RW-1:0] rn;
        logic [DW-1:0] data;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;
    logic   in_fire;
    logic   out_fire;

    assign in_ent    = {in_ctrl, in_rn, in_data};
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_ctrl  = main_q.ctrl & {CW{out_valid}};
    assign out_rn    = main_q.rn;
    assign out_data  = main_q.data;
    assign occ       = state_occ(state_q);

    generate
        if (SKID != 32'd0) begin : g_skid
            logic in_ready_q;
            logic in_ready_d;

            // Ready is registered from the next state so no combinational ready path exists.
            assign in_ready_d = (state_d != ST_TWO);

            // Registered upstream ready.
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= in_ready_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    // Next-state and storage update; flush squashes held entries and their control bits.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d     = ST_EMPTY;
            main_d.ctrl = '0;
            skid_d.ctrl = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_ent;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_ent;
                    end else if (in_fire && (SKID != 32'd0)) begin
                        state_d = ST_TWO;
                        skid_d  = in_ent;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
